// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
//
// Purpose: shared definitions for the fetch-stage next-PC sequencer.
//   - pc_seq_state_e : redirect-holding state encoding (IDLE / PEND)
//   - PC_STEP        : sequential fetch increment in bytes
//   - pc_seq_incr()  : sequential successor of a PC, modulo 2^32
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no redirect held
    ST_PEND = 1'b1   // pend_target_q holds a branch redirect awaiting release
  } pc_seq_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Sequential successor; the 32-bit result wraps 'hFFFFFFFC to 0.
  function automatic logic [31:0] pc_seq_incr(input logic [31:0] pc_val);
    return pc_val + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose: next-PC controller for the fetch stage. Each cycle it chooses the
// address the fetch PC register loads, in priority order: reset, exception
// entry, exception return, stall hold, branch redirect, held redirect,
// sequential fetch. A branch that resolves while fetch is stalled is held in
// pend_target_q and applied on the first unstalled cycle.
//
// Parameters:
//   ADDR_MIN      reset PC (must match the fetch stage)
//   ADDR_HANDLER  exception handler entry address
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   pc          in   current fetch PC
//   stall       in   hazard stall, fetch holds
//   br_valid    in   taken branch/jump resolved in decode this cycle
//   br_target   in   redirect target, qualified by br_valid
//   exc_req     in   CP0 takes an exception/interrupt this cycle
//   eret_req    in   eret commits this cycle
//   epc         in   return address, qualified by eret_req
//   next_pc     out  value fetch PC loads at the next edge (combinational)
//   flush_f     out  kill the instruction currently in fetch
//   bd_f        out  instruction in fetch is a branch delay slot
//   pend_valid  out  a redirect is currently held
//
// Build option: define PC_SEQ_DELAY_SLOT_EN for MIPS delay-slot semantics
// (branches do not flush fetch, bd_f reports the delay slot). Without it,
// applying a branch redirect flushes fetch and bd_f is tied low.
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] ADDR_MIN     = 32'h0000_3000,
  parameter logic [31:0] ADDR_HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        flush_f,
  output logic        bd_f,
  output logic        pend_valid
);

  pc_seq_state_e state_q, state_d;
  logic [31:0]   pend_target_q, pend_target_d;

  // Exception entry or return overrides any branch activity this cycle.
  logic kill;
  assign kill = exc_req | eret_req;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    unique case (state_q)
      ST_IDLE: begin
        if (br_valid && stall && !kill) begin
          state_d       = ST_PEND;
          pend_target_d = br_target;
        end
      end
      ST_PEND: begin
        // Leaving PEND either applies the held target (!stall) or discards
        // it (exception/eret). Decode re-presents the same branch while
        // stalled, so refreshing the target is harmless.
        if (kill || !stall) begin
          state_d = ST_IDLE;
        end else if (br_valid) begin
          pend_target_d = br_target;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- output logic ----
  logic in_pend;
  assign in_pend    = (state_q == ST_PEND);
  assign pend_valid = in_pend;

  always_comb begin
    next_pc = pc_seq_incr(pc);
    if (reset) begin
      next_pc = ADDR_MIN;
    end else if (exc_req) begin
      next_pc = ADDR_HANDLER;
    end else if (eret_req) begin
      next_pc = epc;
    end else if (stall) begin
      next_pc = pc;
    end else if (br_valid) begin
      next_pc = br_target;
    end else if (in_pend) begin
      next_pc = pend_target_q;
    end
  end

  always_comb begin
    flush_f = 1'b0;
    bd_f    = 1'b0;
    if (!reset) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
      // The fetch-stage instruction behind a branch is its delay slot and
      // always executes; only exception entry/return kill it.
      flush_f = kill;
      bd_f    = (br_valid | in_pend) & ~kill;
`else
      // A branch redirect is applied when it wins unstalled, or when a held
      // redirect is released; the wrong-path fetch is killed in both cases.
      flush_f = kill | (br_valid & ~stall) | (in_pend & ~stall);
      bd_f    = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the stimulus process applies one vector
// per cycle and queues its hand-computed expectation; the monitor pops one
// expectation per cycle on the falling edge and compares the outputs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] next_pc;
  logic        flush_f;
  logic        bd_f;
  logic        pend_valid;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        fl;
    logic        bd;
    logic        pv;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(
    .ADDR_MIN    (32'h0000_3000),
    .ADDR_HANDLER(32'h0000_4180)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .next_pc   (next_pc),
    .flush_f   (flush_f),
    .bd_f      (bd_f),
    .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got 'h%08h, expected 'h%08h", nm, act, req);
    end
  endtask

  // Monitor: outputs are combinational and present every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp({e.name, ".next_pc"},    next_pc,           e.npc);
      cmp({e.name, ".flush_f"},    {31'd0, flush_f},    {31'd0, e.fl});
      cmp({e.name, ".bd_f"},       {31'd0, bd_f},       {31'd0, e.bd});
      cmp({e.name, ".pend_valid"}, {31'd0, pend_valid}, {31'd0, e.pv});
    end
  end

  task automatic drv(input logic r, input logic [31:0] p, input logic s,
                     input logic b, input logic [31:0] t, input logic x,
                     input logic er, input logic [31:0] ep);
    reset = r; pc = p; stall = s; br_valid = b; br_target = t;
    exc_req = x; eret_req = er; epc = ep;
  endtask

  // Expectation for the current vector; flush/bd given for both builds.
  task automatic step(input string nm, input logic [31:0] npc,
                      input logic fl_ds, input logic fl_nd,
                      input logic bd_ds, input logic pv);
    exp_t e;
    e.name = nm;
    e.npc  = npc;
    e.pv   = pv;
`ifdef PC_SEQ_DELAY_SLOT_EN
    e.fl = fl_ds;
    e.bd = bd_ds;
`else
    e.fl = fl_nd;
    e.bd = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset for two cycles, then sequential fetch.
    drv(1, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    step("rst0", 32'h3000, 0, 0, 0, 0);
    step("rst1", 32'h3000, 0, 0, 0, 0);
    drv(0, 32'h3000, 0, 0, 32'h0, 0, 0, 32'h0);
    step("seq0", 32'h3004, 0, 0, 0, 0);
    drv(0, 32'h3004, 0, 0, 32'h0, 0, 0, 32'h0);
    step("seq1", 32'h3008, 0, 0, 0, 0);

    // Unstalled branch.
    drv(0, 32'h3010, 0, 1, 32'h3100, 0, 0, 32'h0);
    step("br", 32'h3100, 0, 1, 1, 0);
    drv(0, 32'h3100, 0, 0, 32'h0, 0, 0, 32'h0);
    step("br_after", 32'h3104, 0, 0, 0, 0);

    // Branch held over a 3-cycle stall, released on the first free cycle.
    drv(0, 32'h3104, 1, 1, 32'h3200, 0, 0, 32'h0);
    step("pend_s1", 32'h3104, 0, 0, 1, 0);
    step("pend_s2", 32'h3104, 0, 0, 1, 1);
    step("pend_s3", 32'h3104, 0, 0, 1, 1);
    drv(0, 32'h3104, 0, 0, 32'h0, 0, 0, 32'h0);
    step("pend_rel", 32'h3200, 0, 1, 1, 1);
    drv(0, 32'h3200, 0, 0, 32'h0, 0, 0, 32'h0);
    step("pend_idle", 32'h3204, 0, 0, 0, 0);

    // Exception during a held redirect discards it.
    drv(0, 32'h3204, 1, 1, 32'h3200, 0, 0, 32'h0);
    step("exc_s1", 32'h3204, 0, 0, 1, 0);
    drv(0, 32'h3204, 1, 1, 32'h3200, 1, 0, 32'h0);
    step("exc_s2", 32'h4180, 1, 1, 0, 1);
    drv(0, 32'h4180, 1, 0, 32'h0, 0, 0, 32'h0);
    step("exc_s3", 32'h4180, 0, 0, 0, 0);
    drv(0, 32'h4180, 0, 0, 32'h0, 0, 0, 32'h0);
    step("exc_free", 32'h4184, 0, 0, 0, 0);

    // Exception beats eret; then eret alone.
    drv(0, 32'h4184, 0, 0, 32'h0, 1, 1, 32'h3040);
    step("exc_eret", 32'h4180, 1, 1, 0, 0);
    drv(0, 32'h4180, 0, 0, 32'h0, 0, 1, 32'h3040);
    step("eret", 32'h3040, 1, 1, 0, 0);

    // Address wrap.
    drv(0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0, 32'h0);
    step("wrap", 32'h0, 0, 0, 0, 0);

    // Plain stall without a branch.
    drv(0, 32'h3040, 1, 0, 32'h0, 0, 0, 32'h0);
    step("stall", 32'h3040, 0, 0, 0, 0);

    // Reset while a redirect is held.
    drv(0, 32'h3040, 1, 1, 32'h3500, 0, 0, 32'h0);
    step("rp_s1", 32'h3040, 0, 0, 1, 0);
    step("rp_s2", 32'h3040, 0, 0, 1, 1);
    drv(1, 32'h3040, 1, 1, 32'h3500, 0, 0, 32'h0);
    step("rp_rst0", 32'h3000, 0, 0, 0, 1);
    drv(1, 32'h3040, 0, 0, 32'h0, 0, 0, 32'h0);
    step("rp_rst1", 32'h3000, 0, 0, 0, 0);
    drv(0, 32'h3000, 0, 0, 32'h0, 0, 0, 32'h0);
    step("rp_after", 32'h3004, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
